// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 register file (SR, Cause, EPC) and exception/interrupt arbiter beside the M stage.
// Latency: req, c0_out and epc_out are combinational in the current cycle; SR, Cause and EPC update on the next rising edge.
// Backpressure: none. A taken request simply discards any mtc0 or eret issued in the same cycle.
// Ports:
//   clk, reset (synchronous, active-low)
//   we, c0_addr, c0_in : mtc0 write port (12 = SR, 13 = Cause, 14 = EPC)
//   eret               : return from exception, clears EXL
//   exc_code, is_bd, vpc, hw_int : M-stage exception source, delay-slot flag, PC, interrupt lines
//   c0_out             : mfc0 read data
//   epc_out            : EPC with same-cycle mtc0 bypass
//   req                : exception/interrupt taken this cycle
//   handler_pc         : constant handler entry address
module cp0_unit #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  c0_addr,
   input  logic [31:0] c0_in,
   input  logic        eret,
   input  logic [4:0]  exc_code,
   input  logic        is_bd,
   input  logic [31:0] vpc,
   input  logic [5:0]  hw_int,
   output logic [31:0] c0_out,
   output logic [31:0] epc_out,
   output logic        req,
   output logic [31:0] handler_pc
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_cd;
   // EPC, low two bits always zero
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        req_raw;
   logic [31:0] vpc_al;
   logic [31:0] c0_in_al;
   logic [31:0] epc_next;
   logic [31:0] sr_val;
   logic [31:0] cause_val;
   logic        epc_wr;

   // Requests use live hw_int, not the registered IP copy.
   assign int_req = ie & ~exl & (|(hw_int & im));
   assign exc_req = ~exl & (exc_code != 5'd0);
   assign req_raw = int_req | exc_req;

   // Masking with a constant keeps every input bit in use while forcing word alignment.
   assign vpc_al   = vpc   & 32'hFFFF_FFFC;
   assign c0_in_al = c0_in & 32'hFFFF_FFFC;

   // A delay-slot instruction restarts at its branch; modulo-2^32 wrap is intended.
   assign epc_next = is_bd ? (vpc_al - 32'd4) : vpc_al;

   assign epc_wr = we & (c0_addr == ADDR_EPC);

   assign sr_val    = {16'd0, im, 8'd0, exl, ie};
   assign cause_val = {bd, 15'd0, ip, 3'd0, exc_cd, 2'd0};

   always_ff @(posedge clk) begin
      if (!reset) begin
         im     <= 6'd0;
         exl    <= 1'b0;
         ie     <= 1'b0;
         bd     <= 1'b0;
         ip     <= 6'd0;
         exc_cd <= 5'd0;
         epc    <= 32'd0;
      end else begin
         ip <= hw_int;
         if (req_raw) begin
            // Interrupt wins over a simultaneous synchronous exception.
            exl    <= 1'b1;
            exc_cd <= int_req ? 5'd0 : exc_code;
            bd     <= is_bd;
            epc    <= epc_next;
         end else if (eret) begin
            exl <= 1'b0;
         end else if (we) begin
            case (c0_addr)
               ADDR_SR: begin
                  im  <= c0_in[15:10];
                  exl <= c0_in[1];
                  ie  <= c0_in[0];
               end
               ADDR_EPC: epc <= c0_in_al;
               default: ;
            endcase
         end
      end
   end

   // All outputs except handler_pc are forced low while reset is held.
   always_comb begin
      c0_out = 32'd0;
      if (reset) begin
         case (c0_addr)
            ADDR_SR:    c0_out = sr_val;
            ADDR_CAUSE: c0_out = cause_val;
            ADDR_EPC:   c0_out = epc;
            default:    c0_out = 32'd0;
         endcase
      end
   end

   // Bypass lets an eret right after mtc0 EPC see the new target.
   assign epc_out    = reset ? (epc_wr ? c0_in_al : epc) : 32'd0;
   assign req        = reset & req_raw;
   assign handler_pc = HANDLER_PC;

endmodule
